// File: rtl/gmii_rx_frame_ctrl.sv
// GMII receive framer: strips preamble/SFD, forwards frame bytes as sop/eop,
// checks CRC-32, length and PHY error, and keeps saturating frame/drop counters.
module gmii_rx_frame_ctrl #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518,
   parameter int PRE_MIN = 1,
   parameter int CNT_W   = 16
) (
   input  logic             gmii_rxc,
   input  logic             rst,
   input  logic             gmii_rx_dv,
   input  logic             gmii_rx_err,
   input  logic [7:0]       gmii_rd,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic             rx_sop,
   output logic             rx_eop,
   output logic             rx_stat_vld,
   output logic             rx_stat_ok,
   output logic             rx_stat_crc_err,
   output logic             rx_stat_len_err,
   output logic             rx_stat_phy_err,
   output logic [15:0]      rx_len,
   output logic [CNT_W-1:0] rx_frame_cnt,
   output logic [CNT_W-1:0] rx_drop_cnt
);

   typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

   localparam int            PW        = $clog2(PRE_MIN + 2);
   localparam logic [PW-1:0] PRE_MIN_C = PW'(PRE_MIN);
   localparam logic [15:0]   MIN_C     = 16'(MIN_LEN);
   localparam logic [15:0]   MAX_C     = 16'(MAX_LEN);
   localparam logic [31:0]   CRC_INIT  = 32'hFFFF_FFFF;
   localparam logic [31:0]   RESIDUE   = 32'hC704_DD7B;

   function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                            input logic [7:0]  d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [31:0] rev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++)
         r[i] = v[31-i];
      return r;
   endfunction

   state_t            state_q, state_d;
   logic [PW-1:0]     pre_q, pre_d;
   logic [31:0]       crc_q, crc_d;
   logic [15:0]       len_q, len_d;
   logic [7:0]        hold_q, hold_d;
   logic              phy_q, phy_d;
   logic              dv_q;

   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d;
   logic              sop_q, sop_d;
   logic              eop_q, eop_d;
   logic              svld_q, svld_d;
   logic              sok_q, sok_d;
   logic              scrc_q, scrc_d;
   logic              slen_q, slen_d;
   logic              sphy_q, sphy_d;
   logic [15:0]       rxlen_q, rxlen_d;
   logic [CNT_W-1:0]  fcnt_q, fcnt_d;
   logic [CNT_W-1:0]  dcnt_q, dcnt_d;

   logic              emit, last, drop_inc, crc_bad, len_bad;

   always_comb begin
      state_d  = state_q;
      pre_d    = pre_q;
      crc_d    = crc_q;
      len_d    = len_q;
      hold_d   = hold_q;
      phy_d    = phy_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      sop_d    = 1'b0;
      eop_d    = 1'b0;
      svld_d   = 1'b0;
      sok_d    = sok_q;
      scrc_d   = scrc_q;
      slen_d   = slen_q;
      sphy_d   = sphy_q;
      rxlen_d  = rxlen_q;
      fcnt_d   = fcnt_q;
      dcnt_d   = dcnt_q;
      emit     = 1'b0;
      last     = 1'b0;
      drop_inc = 1'b0;
      crc_bad  = 1'b0;
      len_bad  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // dv already high when reset released: wait for its next rising edge
            if (gmii_rx_dv && dv_q) begin
               state_d = IDLE;
            end else if (gmii_rx_dv && gmii_rd == 8'h55 && !gmii_rx_err) begin
               state_d = PRE;
               pre_d   = PW'(1);
            end else if (gmii_rx_dv || gmii_rx_err) begin
               state_d  = DROP;
               drop_inc = 1'b1;
            end
         end
         PRE: begin
            if (!gmii_rx_dv) begin
               state_d  = IDLE;
               drop_inc = 1'b1;
            end else if (gmii_rx_err) begin
               state_d  = DROP;
               drop_inc = 1'b1;
            end else if (gmii_rd == 8'h55) begin
               if (pre_q != '1)
                  pre_d = pre_q + PW'(1);
            end else if (gmii_rd == 8'hD5 && pre_q >= PRE_MIN_C) begin
               state_d = DATA;
               crc_d   = CRC_INIT;
               len_d   = 16'd0;
               phy_d   = 1'b0;
            end else begin
               state_d  = DROP;
               drop_inc = 1'b1;
            end
         end
         DATA: begin
            if (!gmii_rx_dv) begin
               state_d = IDLE;
               if (len_q == 16'd0) begin
                  drop_inc = 1'b1;
               end else begin
                  emit    = 1'b1;
                  last    = 1'b1;
                  // register is LSB-first; residue is quoted MSB-first
                  crc_bad = (rev32(crc_q) != RESIDUE);
                  len_bad = (len_q < MIN_C);
               end
            end else if (len_q == MAX_C) begin
               state_d = DROP;
               emit    = 1'b1;
               last    = 1'b1;
               len_bad = 1'b1;
            end else begin
               crc_d  = crc_byte(crc_q, gmii_rd);
               len_d  = len_q + 16'd1;
               hold_d = gmii_rd;
               phy_d  = phy_q | gmii_rx_err;
               emit   = (len_q != 16'd0);
            end
         end
         DROP: begin
            if (!gmii_rx_dv)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (emit) begin
         valid_d = 1'b1;
         data_d  = hold_q;
         sop_d   = (len_q == 16'd1);
         eop_d   = last;
      end
      if (last) begin
         svld_d  = 1'b1;
         scrc_d  = crc_bad;
         slen_d  = len_bad;
         sphy_d  = phy_q;
         sok_d   = !(crc_bad || len_bad || phy_q);
         rxlen_d = len_q;
         if (fcnt_q != '1)
            fcnt_d = fcnt_q + 1'b1;
      end
      if (drop_inc && dcnt_q != '1)
         dcnt_d = dcnt_q + 1'b1;
   end

   always_ff @(posedge gmii_rxc) begin
      if (rst) begin
         state_q <= IDLE;
         pre_q   <= '0;
         crc_q   <= CRC_INIT;
         len_q   <= 16'd0;
         hold_q  <= 8'd0;
         phy_q   <= 1'b0;
         dv_q    <= gmii_rx_dv;
         data_q  <= 8'd0;
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         svld_q  <= 1'b0;
         sok_q   <= 1'b0;
         scrc_q  <= 1'b0;
         slen_q  <= 1'b0;
         sphy_q  <= 1'b0;
         rxlen_q <= 16'd0;
         fcnt_q  <= '0;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         crc_q   <= crc_d;
         len_q   <= len_d;
         hold_q  <= hold_d;
         phy_q   <= phy_d;
         dv_q    <= gmii_rx_dv;
         data_q  <= data_d;
         valid_q <= valid_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         svld_q  <= svld_d;
         sok_q   <= sok_d;
         scrc_q  <= scrc_d;
         slen_q  <= slen_d;
         sphy_q  <= sphy_d;
         rxlen_q <= rxlen_d;
         fcnt_q  <= fcnt_d;
         dcnt_q  <= dcnt_d;
      end
   end

   assign rx_data         = data_q;
   assign rx_valid        = valid_q;
   assign rx_sop          = sop_q;
   assign rx_eop          = eop_q;
   assign rx_stat_vld     = svld_q;
   assign rx_stat_ok      = sok_q;
   assign rx_stat_crc_err = scrc_q;
   assign rx_stat_len_err = slen_q;
   assign rx_stat_phy_err = sphy_q;
   assign rx_len          = rxlen_q;
   assign rx_frame_cnt    = fcnt_q;
   assign rx_drop_cnt     = dcnt_q;

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Bench for gmii_rx_frame_ctrl: directed and random bursts checked against
// a frame-level reference model (beats, latency, status, counters).
module tb_gmii_rx_frame_ctrl;

   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;
   localparam int PRE_MIN = 1;
   localparam int CNT_W   = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             dv  = 1'b0;
   logic             err = 1'b0;
   logic [7:0]       rd  = 8'h00;
   logic [7:0]       rx_data;
   logic             rx_valid, rx_sop, rx_eop, rx_stat_vld, rx_stat_ok;
   logic             rx_stat_crc_err, rx_stat_len_err, rx_stat_phy_err;
   logic [15:0]      rx_len;
   logic [CNT_W-1:0] rx_frame_cnt, rx_drop_cnt;

   always #4 clk = ~clk;

   gmii_rx_frame_ctrl #(
      .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .PRE_MIN(PRE_MIN), .CNT_W(CNT_W)
   ) dut (
      .gmii_rxc(clk), .rst(rst), .gmii_rx_dv(dv), .gmii_rx_err(err),
      .gmii_rd(rd), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_stat_vld(rx_stat_vld),
      .rx_stat_ok(rx_stat_ok), .rx_stat_crc_err(rx_stat_crc_err),
      .rx_stat_len_err(rx_stat_len_err), .rx_stat_phy_err(rx_stat_phy_err),
      .rx_len(rx_len), .rx_frame_cnt(rx_frame_cnt), .rx_drop_cnt(rx_drop_cnt)
   );

   typedef struct {
      int         cyc;
      logic [7:0] data;
      bit         sop, eop, ok, crc, lerr, phy;
      int         len;
   } beat_t;

   beat_t      expq[$];
   logic [7:0] bq[$];
   bit         erq[$];
   int         n_cmp = 0, n_bad = 0, cyc = 0;
   int         exp_frames = 0, exp_drops = 0, last_len = 0;
   bit         last_ok = 1'b0;
   beat_t      mb;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] crc_raw(input logic [7:0] f[$]);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (f[k]) begin
         c = c ^ {24'h0, f[k]};
         for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   // good frame: trailing 4 bytes equal the inverted CRC of the rest, LSB first
   function automatic bit fcs_ok(input logic [7:0] f[$]);
      logic [7:0]  body[$];
      logic [31:0] c;
      int          n;
      n = f.size();
      if (n < 4)
         return crc_raw(f) == 32'hDEBB_20E3;
      for (int k = 0; k < n - 4; k++)
         body.push_back(f[k]);
      c = ~crc_raw(body);
      return c == {f[n-1], f[n-2], f[n-3], f[n-4]};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rx_valid) begin
         chk("spurious_valid", 32'(expq.size() != 0), 32'd1);
         if (expq.size() != 0) begin
            mb = expq.pop_front();
            chk("beat_cyc", 32'(cyc), 32'(mb.cyc));
            chk("data", 32'(rx_data), 32'(mb.data));
            chk("sop", 32'(rx_sop), 32'(mb.sop));
            chk("eop", 32'(rx_eop), 32'(mb.eop));
            chk("stat_vld", 32'(rx_stat_vld), 32'(mb.eop));
            if (mb.eop) begin
               chk("stat_ok", 32'(rx_stat_ok), 32'(mb.ok));
               chk("crc_err", 32'(rx_stat_crc_err), 32'(mb.crc));
               chk("len_err", 32'(rx_stat_len_err), 32'(mb.lerr));
               chk("phy_err", 32'(rx_stat_phy_err), 32'(mb.phy));
               chk("rx_len", 32'(rx_len), 32'(mb.len));
            end
         end
      end else begin
         chk("stat_vld_idle", 32'(rx_stat_vld), 32'd0);
         if (expq.size() != 0 && expq[0].cyc <= cyc) begin
            chk("beat_missing", 32'(rx_valid), 32'd1);
            void'(expq.pop_front());
         end
      end
   end

   task automatic mk_frame(input int npre, input int flen, input bit flip,
                           input int errpos);
      logic [7:0]  pl[$];
      logic [31:0] c;
      int          p;
      bq.delete();
      erq.delete();
      repeat (npre) begin
         bq.push_back(8'h55);
         erq.push_back(1'b0);
      end
      bq.push_back(8'hD5);
      erq.push_back(1'b0);
      if (flen < 4) begin
         repeat (flen) pl.push_back(8'($urandom));
      end else begin
         repeat (flen - 4) pl.push_back(8'($urandom));
         c = ~crc_raw(pl);
         for (int k = 0; k < 4; k++)
            pl.push_back(c[8*k +: 8]);
      end
      foreach (pl[k]) begin
         bq.push_back(pl[k]);
         erq.push_back(1'b0);
      end
      if (flip && flen > 0) begin
         p = npre + 1 + int'($urandom_range(0, flen - 1));
         bq[p] = bq[p] ^ 8'(1 << $urandom_range(0, 7));
      end
      if (errpos > 0)
         erq[npre + errpos] = 1'b1;
   endtask

   task automatic send(input int gap);
      logic [7:0] fr[$];
      int         n, i, fs, flen, emit;
      bit         phy_e, crc_e, len_e, ok_e;
      beat_t      nb;
      n = bq.size();
      i = 0;
      fs = -1;
      emit = 0;
      phy_e = 1'b0;
      crc_e = 1'b0;
      len_e = 1'b0;
      ok_e = 1'b0;
      while (i < n && bq[i] == 8'h55 && !erq[i])
         i++;
      if (n > 0) begin
         if (i < n && i >= PRE_MIN && bq[i] == 8'hD5 && !erq[i]) begin
            fs = i + 1;
            flen = n - fs;
            if (flen == 0) begin
               exp_drops++;
            end else begin
               emit = (flen > MAX_LEN) ? MAX_LEN : flen;
               for (int k = 0; k < emit; k++)
                  phy_e |= erq[fs + k];
               for (int k = 0; k < flen; k++)
                  fr.push_back(bq[fs + k]);
               crc_e = (flen > MAX_LEN) ? 1'b0 : !fcs_ok(fr);
               len_e = (emit < MIN_LEN) || (flen > MAX_LEN);
               ok_e  = !(crc_e || len_e || phy_e);
               exp_frames++;
               last_len = emit;
               last_ok  = ok_e;
            end
         end else begin
            exp_drops++;
         end
      end
      for (int p = 0; p < n; p++) begin
         @(negedge clk);
         dv = 1'b1;
         rd = bq[p];
         err = erq[p];
         if (emit > 0 && p >= fs && p < fs + emit) begin
            nb.cyc = cyc + 2;
            nb.data = bq[p];
            nb.sop = (p == fs);
            nb.eop = (p == fs + emit - 1);
            nb.ok = ok_e;
            nb.crc = crc_e;
            nb.lerr = len_e;
            nb.phy = phy_e;
            nb.len = emit;
            expq.push_back(nb);
         end
      end
      repeat (gap) begin
         @(negedge clk);
         dv = 1'b0;
         err = 1'b0;
         rd = 8'($urandom);
      end
   endtask

   task automatic chk_counters(input string tag);
      @(negedge clk);
      chk({tag, "_frame_cnt"}, 32'(rx_frame_cnt), 32'(exp_frames));
      chk({tag, "_drop_cnt"}, 32'(rx_drop_cnt), 32'(exp_drops));
      chk({tag, "_held_len"}, 32'(rx_len), 32'(last_len));
      chk({tag, "_held_ok"}, 32'(rx_stat_ok), 32'(last_ok));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(rx_valid), 32'd0);
      chk({tag, "_sop_eop"}, 32'({rx_sop, rx_eop}), 32'd0);
      chk({tag, "_data"}, 32'(rx_data), 32'd0);
      chk({tag, "_stat"}, 32'({rx_stat_vld, rx_stat_ok, rx_stat_crc_err,
                               rx_stat_len_err, rx_stat_phy_err}), 32'd0);
      chk({tag, "_len"}, 32'(rx_len), 32'd0);
      chk({tag, "_cnts"}, {rx_frame_cnt, rx_drop_cnt}, 32'd0);
   endtask

   initial begin
      int kind, flen, r;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;

      mk_frame(7, 64, 1'b0, 0);     send(2); chk_counters("t1_good");
      mk_frame(7, 64, 1'b1, 0);     send(2); chk_counters("t2_crc");
      mk_frame(7, 64, 1'b0, 20);    send(2); chk_counters("t3_phy");
      mk_frame(7, 60, 1'b0, 0);     send(2); chk_counters("t4_short");
      mk_frame(7, 1600, 1'b0, 0);   send(3); chk_counters("t4_long");
      mk_frame(3, 1518, 1'b0, 0);   send(2); chk_counters("max_len");
      mk_frame(3, 1519, 1'b0, 0);   send(2); chk_counters("max_len_p1");
      mk_frame(1, 1, 1'b0, 0);      send(2); chk_counters("one_byte");

      bq = '{8'h55, 8'h55, 8'h5A, 8'h12, 8'h34, 8'hD5};
      erq = '{0, 0, 0, 0, 0, 0};
      send(2); chk_counters("t5_badpre");
      bq = '{8'h55, 8'h55};
      erq = '{0, 0};
      send(2); chk_counters("t5_pre_gap");
      bq = '{8'h55, 8'hD5};
      erq = '{0, 0};
      send(2); chk_counters("t5_sfd_gap");

      mk_frame(7, 64, 1'b0, 0);     send(1);
      mk_frame(7, 64, 1'b0, 0);     send(1); chk_counters("t6_b2b");

      // reset asserted while data byte 30 is on the bus
      mk_frame(7, 64, 1'b0, 0);
      for (int p = 0; p < bq.size(); p++) begin
         @(negedge clk);
         if (p == 38) begin
            chk_zero("mid_rst");
            exp_frames = 0;
            exp_drops = 0;
            last_len = 0;
            last_ok = 1'b0;
         end
         dv = 1'b1;
         err = 1'b0;
         rd = bq[p];
         rst = (p == 37);
         if (p >= 8 && p <= 35) begin
            mb.cyc = cyc + 2;
            mb.data = bq[p];
            mb.sop = (p == 8);
            mb.eop = 1'b0;
            mb.ok = 1'b0;
            mb.crc = 1'b0;
            mb.lerr = 1'b0;
            mb.phy = 1'b0;
            mb.len = 0;
            expq.push_back(mb);
         end
      end
      @(negedge clk);
      dv = 1'b0;
      chk_counters("after_rst");
      mk_frame(7, 64, 1'b0, 0);     send(2); chk_counters("t6_fourth");

      for (int it = 0; it < 60; it++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 6) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       flen = int'($urandom_range(64, 128));
            else if (r == 6) flen = int'($urandom_range(1, 70));
            else if (r == 7) flen = int'($urandom_range(1514, 1520));
            else if (r == 8) flen = int'($urandom_range(60, 68));
            else             flen = int'($urandom_range(4, 63));
            mk_frame(int'($urandom_range(1, 7)), flen,
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 4) == 0) ?
                        int'($urandom_range(1, flen)) : 0);
         end else begin
            bq.delete();
            erq.delete();
            repeat ($urandom_range(1, 10)) begin
               r = int'($urandom_range(0, 3));
               bq.push_back(r < 2 ? 8'h55 : (r == 2 ? 8'hD5 : 8'($urandom)));
               erq.push_back($urandom_range(0, 7) == 0);
            end
         end
         send(int'($urandom_range(1, 4)));
         if ($urandom_range(0, 1) == 1)
            chk_counters("rand");
      end
      chk_counters("final");
      repeat (4) @(negedge clk);
      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
